// File: rtl/ascon_text_block_packer.sv
// Packs a 32-bit plaintext/ciphertext word stream into 128-bit Ascon rate
// blocks. Each block is tagged with its byte offset, its valid byte count and
// a final-block marker. The final block carries a partial lane right-aligned,
// which is the layout the datapath expects.
//
// Handshakes: a word moves when s_valid && s_ready at a rising clk edge, and a
// block moves when blk_valid && blk_ready at a rising clk edge. Once blk_valid
// is high, the block fields hold steady until the block is taken. s_valid
// need not wait for s_ready.
module ascon_text_block_packer #(
   parameter int LEN_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] text_length,
   input  logic [31:0]      s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [127:0]     blk_data,
   output logic [LEN_W-1:0] blk_position,
   output logic [4:0]       blk_bytes,
   output logic             blk_last,
   output logic             blk_valid,
   input  logic             blk_ready,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, FILL, EMIT, DONE} state_t;

   state_t           state, state_nxt;
   logic [LEN_W-1:0] len_q;      // latched message length
   logic [LEN_W-1:0] pos_q;      // byte offset of the block being built
   logic [4:0]       cnt_q;      // bytes gathered into the current block
   logic [127:0]     buf_q;      // raw block bytes, first byte at [127:120]
   logic [127:0]     buf_nxt;
   logic [LEN_W-1:0] remain;     // message bytes not yet gathered
   logic [2:0]       take;       // bytes the current word contributes
   logic [4:0]       cnt_sum;
   logic             fill_end;
   logic             last_blk;
   logic             next_empty;
   logic [3:0]       n_up, n_lo;
   logic [6:0]       sh_up, sh_lo;

   assign remain     = len_q - pos_q - {{(LEN_W-5){1'b0}}, cnt_q};
   assign take       = (remain >= LEN_W'(4)) ? 3'd4 : remain[2:0];
   assign cnt_sum    = cnt_q + {2'b00, take};
   // Block is complete when it is full or the message has run out.
   assign fill_end   = (cnt_sum == 5'd16) || (remain == {{(LEN_W-3){1'b0}}, take});
   assign last_blk   = (len_q - pos_q) < LEN_W'(16);
   assign next_empty = (pos_q + LEN_W'(16)) == len_q;

   // Merge the top 'take' bytes of s_data into the raw buffer, MSB-first.
   always_comb begin
      int j;
      j       = 0;
      buf_nxt = buf_q;
      for (int k = 0; k < 4; k++) begin
         if (k < int'(take)) begin
            j = int'(cnt_q) + k;
            if (j < 16) buf_nxt[127-8*j -: 8] = s_data[31-8*k -: 8];
         end
      end
   end

   // Lane formatting: unused bytes in the buffer are zero, so shifting a lane
   // right by its empty byte count right-aligns partial lanes, leaves full
   // lanes untouched and turns empty lanes into zero.
   always_comb begin
      n_up     = (cnt_q >= 5'd8) ? 4'd8 : cnt_q[3:0];
      n_lo     = (cnt_q > 5'd8) ? 4'(cnt_q - 5'd8) : 4'd0;
      sh_up    = {4'd8 - n_up, 3'b000};
      sh_lo    = {4'd8 - n_lo, 3'b000};
      blk_data = {buf_q[127:64] >> sh_up, buf_q[63:0] >> sh_lo};
   end

   assign blk_position = pos_q;
   assign blk_bytes    = cnt_q;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and handshake/status outputs.
   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      blk_valid = 1'b0;
      blk_last  = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = (text_length == '0) ? EMIT : FILL;
         end
         FILL: begin
            s_ready = 1'b1;
            if (s_valid && fill_end) state_nxt = EMIT;
         end
         EMIT: begin
            blk_valid = 1'b1;
            blk_last  = last_blk;
            if (blk_ready) begin
               if (last_blk)        state_nxt = DONE;
               else if (next_empty) state_nxt = EMIT;
               else                 state_nxt = FILL;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Length, position, byte count and buffer updates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q <= '0;
         pos_q <= '0;
         cnt_q <= '0;
         buf_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  len_q <= text_length;
                  pos_q <= '0;
                  cnt_q <= '0;
                  buf_q <= '0;
               end
            end
            FILL: begin
               if (s_valid) begin
                  buf_q <= buf_nxt;
                  cnt_q <= cnt_sum;
               end
            end
            EMIT: begin
               if (blk_ready && !last_blk) begin
                  pos_q <= pos_q + LEN_W'(16);
                  cnt_q <= '0;
                  buf_q <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
